// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size codes and FSM states.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    ERR
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: sub-word load extraction/extension and sub-word store merge.
module lsu_lane
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = sext8(byte_sel);
      F3_H:    load_data = sext16(half_sel);
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

  // Stores overwrite only the addressed lane of the previously read word.
  always_comb begin
    store_data = word;
    case (funct3)
      F3_B:    store_data[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    store_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    store_data = wdata;
      default: store_data = word;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit toward a single-cycle data memory; sub-word stores use read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned H/HU/SH/W requests into errors.
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_MISALIGN = 1'b1;
`else
  localparam bit TRAP_MISALIGN = 1'b0;
`endif

  lsu_state_t  state, accept_state;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic [31:0] lane_word, load_data, store_data;
  logic        invalid, misalign;

  // Classification of the request being presented in IDLE.
  always_comb begin
    if (we)
      invalid = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    else
      invalid = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    misalign = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
               (funct3 == F3_W && addr[1:0] != 2'b00);
    if (invalid || (TRAP_MISALIGN && misalign))
      accept_state = ERR;
    else if (!we)
      accept_state = LOAD;
    else if (funct3 == F3_W)
      accept_state = WRITE;
    else
      accept_state = RMW_RD;
  end

  assign lane_word = (state == LOAD) ? mem_rd : word_q;

  lsu_lane u_lane (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .word       (lane_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Memory strobes decode from state, so reset removes mem_we without a clock.
  assign ready  = (state == IDLE);
  assign mem_we = (state == WRITE);
  assign mem_a  = ready ? 32'h0 : {addr_q[31:2], 2'b00};
  assign mem_wd = mem_we ? store_data : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rdata   <= 32'h0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            state   <= accept_state;
          end
        end
        LOAD: begin
          rdata <= load_data;
          done  <= 1'b1;
          state <= IDLE;
        end
        RMW_RD: begin
          word_q <= mem_rd;
          state  <= WRITE;
        end
        WRITE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        ERR: begin
          done  <= 1'b1;
          err   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a behavioural single-cycle data memory.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [64];

  int pass_cnt = 0;
  int total = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [31:0] W20 = 32'hBEEF7F01;
`else
  localparam logic [31:0] W20 = 32'hBEEF5555;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  assign mem_rd = mem[mem_a[7:2]];

  riscv_lsu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .done   (done),
    .err    (err),
    .rdata  (rdata),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int  n;
    int  wecnt;
    bit  seen;
    @(negedge clk);
    check($sformatf("v%0d ready", idx), {31'h0, ready}, 32'h1);
    req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    req = 1'b0;
    n = 1; wecnt = 0; seen = 0;
    while (!seen && n <= 6) begin
      if (mem_we) wecnt++;
      if (done) seen = 1;
      else begin
        n++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      total++;
      $display("FAIL v%0d timeout: no done within 6 cycles", idx);
    end else begin
      check($sformatf("v%0d latency", idx), n, v.lat);
      check($sformatf("v%0d err", idx), {31'h0, err}, {31'h0, v.err});
      check($sformatf("v%0d rdata", idx), rdata, v.rdata);
      check($sformatf("v%0d mem_we cycles", idx), wecnt, v.wecnt);
    end
  endtask

  initial begin
    vecs.push_back(vec_t'{1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1});
    vecs.push_back(vec_t'{1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0});
    vecs.push_back(vec_t'{1'b1, F3_W,  32'h10, 32'h11223344, 32'hDEADBEEF, 1'b0, 2, 1});
    vecs.push_back(vec_t'{1'b1, F3_B,  32'h12, 32'h000000AA, 32'hDEADBEEF, 1'b0, 3, 1});
    vecs.push_back(vec_t'{1'b0, F3_W,  32'h10, 32'h0,        32'h11AA3344, 1'b0, 2, 0});
    vecs.push_back(vec_t'{1'b1, F3_W,  32'h20, 32'h80F07F01, 32'h11AA3344, 1'b0, 2, 1});
    vecs.push_back(vec_t'{1'b0, F3_B,  32'h23, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0});
    vecs.push_back(vec_t'{1'b0, F3_BU, 32'h23, 32'h0,        32'h00000080, 1'b0, 2, 0});
    vecs.push_back(vec_t'{1'b0, F3_H,  32'h22, 32'h0,        32'hFFFF80F0, 1'b0, 2, 0});
    vecs.push_back(vec_t'{1'b0, F3_HU, 32'h20, 32'h0,        32'h00007F01, 1'b0, 2, 0});
    vecs.push_back(vec_t'{1'b1, F3_H,  32'h22, 32'h1234BEEF, 32'h00007F01, 1'b0, 3, 1});
    vecs.push_back(vec_t'{1'b0, F3_W,  32'h20, 32'h0,        32'hBEEF7F01, 1'b0, 2, 0});
    vecs.push_back(vec_t'{1'b0, F3_B,  32'h21, 32'h0,        32'h0000007F, 1'b0, 2, 0});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(vec_t'{1'b0, F3_W,  32'h12, 32'h0,        32'h0000007F, 1'b1, 2, 0});
`else
    vecs.push_back(vec_t'{1'b0, F3_W,  32'h12, 32'h0,        32'h11AA3344, 1'b0, 2, 0});
`endif
    vecs.push_back(vec_t'{1'b0, F3_W,  32'h20, 32'h0,        32'hBEEF7F01, 1'b0, 2, 0});
    vecs.push_back(vec_t'{1'b0, 3'b011, 32'h10, 32'h0,       32'hBEEF7F01, 1'b1, 2, 0});
    vecs.push_back(vec_t'{1'b1, 3'b100, 32'h10, 32'h0,       32'hBEEF7F01, 1'b1, 2, 0});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(vec_t'{1'b1, F3_H,  32'h21, 32'h00005555, 32'hBEEF7F01, 1'b1, 2, 0});
`else
    vecs.push_back(vec_t'{1'b1, F3_H,  32'h21, 32'h00005555, 32'hBEEF7F01, 1'b0, 3, 1});
`endif
    vecs.push_back(vec_t'{1'b0, F3_W,  32'h20, 32'h0,        W20,          1'b0, 2, 0});

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ready", {31'h0, ready}, 32'h1);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset err", {31'h0, err}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset mem_we", {31'h0, mem_we}, 32'h0);
    check("reset mem_a", mem_a, 32'h0);
    check("reset mem_wd", mem_wd, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i], i);
    check("mem 0x10", mem[4], 32'h11AA3344);
    check("mem 0x20", mem[8], W20);

    // Back-to-back: new request accepted in the done cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h20;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    check("b2b first done", {31'h0, done}, 32'h1);
    check("b2b ready in done cycle", {31'h0, ready}, 32'h1);
    check("b2b first rdata", rdata, W20);
    req = 1'b1; funct3 = F3_BU; addr = 32'h12;
    @(negedge clk); req = 1'b0;
    check("b2b accepted", {31'h0, ready}, 32'h0);
    @(negedge clk);
    check("b2b second done", {31'h0, done}, 32'h1);
    check("b2b second rdata", rdata, 32'h000000AA);

    // Request while busy is dropped
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h10;
    @(negedge clk);
    we = 1'b1; wdata = 32'h0;
    @(negedge clk);
    req = 1'b0;
    check("busy done", {31'h0, done}, 32'h1);
    check("busy rdata", rdata, 32'h11AA3344);
    @(negedge clk);
    check("busy ignored ready", {31'h0, ready}, 32'h1);
    check("busy ignored mem_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    check("busy ignored mem", mem[4], 32'h11AA3344);

    // Reset during WRITE of an SH
    req = 1'b1; we = 1'b1; funct3 = F3_H; addr = 32'h10; wdata = 32'h00007777;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    check("rst mid mem_we before", {31'h0, mem_we}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid mem_we async", {31'h0, mem_we}, 32'h0);
    check("rst mid ready", {31'h0, ready}, 32'h1);
    check("rst mid mem_a", mem_a, 32'h0);
    @(negedge clk);
    check("rst mid done", {31'h0, done}, 32'h0);
    check("rst mid mem", mem[4], 32'h11AA3344);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst after done", {31'h0, done}, 32'h0);
    check("rst after ready", {31'h0, ready}, 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
